fifo_unpacker: RTL and testbench
================================

# fifo_unpacker

Downstream consumer of the team's synchronous FIFO: pops DATA_W-wide words from the FIFO's show-ahead read port and serializes each word into RATIO = DATA_W/OUT_W narrower chunks on a valid/ready output stream. It owns the FIFO's pop signal. It guarantees pop is never asserted while the FIFO is empty, because the FIFO has no underflow guard. Sustained throughput is one chunk per cycle with no bubble between words.

## Interface
- DATA_W, default 16: FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, default 4: output chunk width; RATIO = DATA_W/OUT_W, RATIO ≥ 2.
- CNT_W (localparam): $clog2(RATIO), the chunk index width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  DATA_W  FIFO read data; valid in the same cycle as pop (show-ahead).
- fifo_pop_o  out  1  pop strobe to the FIFO; combinational.
- out_valid_o  out  1  chunk available; registered.
- out_data_o  out  OUT_W  current chunk; registered word with a combinational select.
- out_last_o  out  1  current chunk is the final chunk of its word.
- out_ready_i  in  1  downstream accepts the chunk.

## Operation
- Two states:
  - ST_EMPTY: no word held.
  - ST_HOLD: word held in word_q, chunk index idx_q.
- Accept: acc = out_valid_o & out_ready_i.
- Load condition: load = !fifo_empty_i & (state==ST_EMPTY | (acc & out_last_o)).
- fifo_pop_o = load. Pop is never asserted when fifo_empty_i=1.
- On load: word_q ← fifo_data_i, idx_q ← 0, state ← ST_HOLD.
- ST_HOLD, acc, not last: idx_q ← idx_q+1.
- ST_HOLD, acc, last, fifo empty: state ← ST_EMPTY.
- ST_HOLD, no acc: all state held.
  - out_data_o and out_last_o stay stable while out_valid_o=1 and out_ready_i=0.
- out_valid_o = (state==ST_HOLD).
- out_last_o = (idx_q == RATIO-1).
- Chunk select depends on build order:
  - LSB-first: out_data_o = word_q[idx_q*OUT_W +: OUT_W].
  - MSB-first: out_data_o = word_q[(RATIO-1-idx_q)*OUT_W +: OUT_W].
- idx_q arithmetic is CNT_W bits. It never wraps past RATIO-1 because last always reloads or empties.

## Timing
- Reset values: state=ST_EMPTY, idx_q=0, word_q=0, out_valid_o=0, out_data_o=0, out_last_o=0.
- fifo_pop_o=0 during reset and in the first cycle after, since fifo_empty_i is high after a shared reset.
- Latency: word visible at the FIFO (fifo_empty_i=0) in cycle N → pop in cycle N → first chunk valid in cycle N+1.
- Back-to-back: last chunk accepted in cycle N with the FIFO non-empty → pop in cycle N → next word's chunk 0 valid in N+1, with no idle cycle.
- Last chunk accepted while the FIFO is empty → out_valid_o=0 in the next cycle. A word arriving later follows the normal latency.
- out_ready_i may be asserted with out_valid_o=0; this has no effect.
- Reset mid-word: the held word and remaining chunks are discarded and the block returns to ST_EMPTY. No pop occurs in the reset cycle.

## Configuration
- Macro: UNPACK_MSB_FIRST_EN.
  - Defined: chunks are emitted most-significant first.
  - Undefined (default): chunks are emitted least-significant first.
- Timing, handshake and out_last_o behaviour are identical in both builds.

## Structure
- Package fifo_unpack_pkg holds:
  - typedef enum logic {ST_EMPTY, ST_HOLD} unpack_state_t;
  - the default width constants.
- Sub-module unpack_chunk_sel: a combinational DATA_W→OUT_W slice selector on idx_q. It contains the only UNPACK_MSB_FIRST_EN conditional.
- Top level holds the FSM, word_q and idx_q.

## Test plan
Common setup: DATA_W=16, OUT_W=4, with the FIFO instance (DEPTH=8) upstream.
- Single word, LSB build: push 0xA5C3 with out_ready_i=1 → out_data 3,C,5,A on consecutive cycles, out_last_o only on A, exactly one pop.
- Same stimulus, MSB build → A,5,C,3, out_last_o on 3.
- Back-to-back: push 0x1234 and 0xBEEF, out_ready_i=1 → 8 consecutive valid cycles (4,3,2,1,F,E,E,B in LSB build), two pops, no bubble.
- Backpressure: hold out_ready_i=0 for 3 cycles on the second chunk → out_data_o and out_valid_o stable, no pop, then the sequence resumes intact.
- Empty gap: one word drained, 5 idle cycles, push 0x00FF → out_valid_o low during the gap, pop never asserted while empty, first chunk F appears one cycle after the FIFO goes non-empty.
- Reset mid-word after 2 of 4 chunks → the next cycle shows out_valid_o=0 and state ST_EMPTY. A subsequent push 0x9876 emits 6,7,8,9.

Source files
------------

// File: rtl/fifo_unpack_pkg.sv
// Shared types and default widths for the FIFO unpacker.
// The chunk order is selected in unpack_chunk_sel by UNPACK_MSB_FIRST_EN.
package fifo_unpack_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_OUT_W  = 4;

    typedef enum logic {ST_EMPTY, ST_HOLD} unpack_state_t;

endpackage

// File: rtl/unpack_chunk_sel.sv
// Combinational DATA_W->OUT_W slice selector for the unpacker.
// Define UNPACK_MSB_FIRST_EN to emit the most-significant chunk first; default is LSB-first.
module unpack_chunk_sel
    import fifo_unpack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W,
    localparam int RATIO = DATA_W / OUT_W,
    localparam int CNT_W = $clog2(RATIO)
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [CNT_W-1:0]  idx_i,
    output logic [OUT_W-1:0]  chunk_o
);

    logic [CNT_W-1:0] sel;

`ifdef UNPACK_MSB_FIRST_EN
    assign sel = CNT_W'(RATIO - 1) - idx_i;
`else
    assign sel = idx_i;
`endif

    assign chunk_o = word_i[sel*OUT_W +: OUT_W];

endmodule

// File: rtl/fifo_unpacker.sv
// Pops DATA_W words from a show-ahead FIFO and serializes them into OUT_W chunks on valid/ready.
// Chunk order follows UNPACK_MSB_FIRST_EN (see unpack_chunk_sel).
module fifo_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W,
    localparam int RATIO = DATA_W / OUT_W,
    localparam int CNT_W = $clog2(RATIO)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_pop_o,
    output logic              out_valid_o,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    unpack_state_t     state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              acc;
    logic              load;

    assign out_valid_o = (state_q == ST_HOLD);
    assign out_last_o  = (idx_q == LAST_IDX);
    assign acc         = out_valid_o & out_ready_i;
    // Reset gates the pop so a reset cycle never consumes a FIFO word.
    assign load        = !reset & !fifo_empty_i & ((state_q == ST_EMPTY) | (acc & out_last_o));
    assign fifo_pop_o  = load;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        if (load) begin
            word_d  = fifo_data_i;
            idx_d   = '0;
            state_d = ST_HOLD;
        end else if (acc) begin
            if (!out_last_o) begin
                idx_d = idx_q + CNT_W'(1);
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    unpack_chunk_sel #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_chunk_sel (
        .word_i  (word_q),
        .idx_i   (idx_q),
        .chunk_o (out_data_o)
    );

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker: a queue stands in for the upstream FIFO and a
// chunk-list model predicts pop, valid, data and last every cycle. Honours UNPACK_MSB_FIRST_EN.
module tb_fifo_unpacker;

    logic        clk;
    logic        reset;
    logic        fifo_empty_i;
    logic [15:0] fifo_data_i;
    logic        fifo_pop_o;
    logic        out_valid_o;
    logic [3:0]  out_data_o;
    logic        out_last_o;
    logic        out_ready_i;

    typedef struct {
        logic [3:0] data;
        logic       last;
    } chunk_t;

    logic [15:0] fifo_q[$];
    chunk_t      exp_q[$];
    logic [3:0]  acc_log[$];
    logic [3:0]  want[$];
    int          vectors;
    int          miscompares;
    int          pop_count;

    fifo_unpacker #(
        .DATA_W (16),
        .OUT_W  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pop_o   (fifo_pop_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A popped word becomes a list of four chunks in emission order.
    function automatic void load_word(input logic [15:0] w);
        chunk_t c;
        int     pos;
        for (int k = 0; k < 4; k++) begin
`ifdef UNPACK_MSB_FIRST_EN
            pos = 3 - k;
`else
            pos = k;
`endif
            c.data = w[pos*4 +: 4];
            c.last = (k == 3);
            exp_q.push_back(c);
        end
    endfunction

    // One clock: drive inputs, compare at negedge, then advance the model at posedge.
    task automatic cycle(input bit rst, input bit rdy);
        bit          exp_pop;
        bit          exp_valid;
        logic [15:0] w;
        reset        = rst;
        out_ready_i  = rdy;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        exp_pop   = !rst && (fifo_q.size() != 0) &&
                    ((exp_q.size() == 0) || (rdy && exp_q.size() == 1));
        vectors++;
        if (out_valid_o !== exp_valid) begin
            miscompares++;
            $display("[TB] FAIL valid @%0t: got %0b want %0b", $time, out_valid_o, exp_valid);
        end
        vectors++;
        if (fifo_pop_o !== exp_pop) begin
            miscompares++;
            $display("[TB] FAIL pop @%0t: got %0b want %0b", $time, fifo_pop_o, exp_pop);
        end
        if (exp_valid) begin
            vectors++;
            if (out_data_o !== exp_q[0].data) begin
                miscompares++;
                $display("[TB] FAIL data @%0t: got %h want %h", $time, out_data_o, exp_q[0].data);
            end
            vectors++;
            if (out_last_o !== exp_q[0].last) begin
                miscompares++;
                $display("[TB] FAIL last @%0t: got %0b want %0b", $time, out_last_o, exp_q[0].last);
            end
        end
        if (fifo_pop_o === 1'b1) pop_count++;
        if (out_valid_o === 1'b1 && rdy && !rst) acc_log.push_back(out_data_o);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            fifo_q.delete();
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (exp_pop) begin
                w = fifo_q.pop_front();
                load_word(w);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        reset        = 1'b0;
        out_ready_i  = 1'b0;
        fifo_empty_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_data_o !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h want 0", out_data_o);
        end
        vectors++;
        if (out_last_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_last: got %0b want 0", out_last_o);
        end
        vectors++;
        if (out_valid_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: valid %0b pop %0b want 0 0", out_valid_o, fifo_pop_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int pops0;
        acc_log.delete();
        pops0 = pop_count;
        fifo_q.push_back(16'hA5C3);
        repeat (7) cycle(1'b0, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
        want = '{4'hA, 4'h5, 4'hC, 4'h3};
`else
        want = '{4'h3, 4'hC, 4'h5, 4'hA};
`endif
        vectors++;
        if (acc_log.size() != want.size()) begin
            miscompares++;
            $display("[TB] FAIL single_len: got %0d want %0d", acc_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (acc_log[i] !== want[i]) begin
                    miscompares++;
                    $display("[TB] FAIL single_seq[%0d]: got %h want %h", i, acc_log[i], want[i]);
                end
            end
        end
        vectors++;
        if (pop_count - pops0 != 1) begin
            miscompares++;
            $display("[TB] FAIL single_pops: got %0d want 1", pop_count - pops0);
        end
    endtask

    task automatic test_back_to_back();
        int pops0;
        acc_log.delete();
        pops0 = pop_count;
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'hBEEF);
        repeat (11) cycle(1'b0, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
        want = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hE, 4'hE, 4'hF};
`else
        want = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hE, 4'hE, 4'hB};
`endif
        vectors++;
        if (acc_log.size() != want.size()) begin
            miscompares++;
            $display("[TB] FAIL b2b_len: got %0d want %0d", acc_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (acc_log[i] !== want[i]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_seq[%0d]: got %h want %h", i, acc_log[i], want[i]);
                end
            end
        end
        vectors++;
        if (pop_count - pops0 != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_pops: got %0d want 2", pop_count - pops0);
        end
    endtask

    task automatic test_backpressure();
        acc_log.delete();
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'h5678);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
        want = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`else
        want = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
`endif
        vectors++;
        if (acc_log.size() != want.size()) begin
            miscompares++;
            $display("[TB] FAIL bp_len: got %0d want %0d", acc_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (acc_log[i] !== want[i]) begin
                    miscompares++;
                    $display("[TB] FAIL bp_seq[%0d]: got %h want %h", i, acc_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_empty_gap();
        int pops0;
        fifo_q.push_back(16'h5A5A);
        repeat (6) cycle(1'b0, 1'b1);
        acc_log.delete();
        pops0 = pop_count;
        repeat (5) cycle(1'b0, 1'b1);
        vectors++;
        if (pop_count != pops0 || acc_log.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL gap_idle: pops %0d chunks %0d want 0 0", pop_count - pops0, acc_log.size());
        end
        fifo_q.push_back(16'h00FF);
        repeat (6) cycle(1'b0, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
        want = '{4'h0, 4'h0, 4'hF, 4'hF};
`else
        want = '{4'hF, 4'hF, 4'h0, 4'h0};
`endif
        vectors++;
        if (acc_log.size() != want.size()) begin
            miscompares++;
            $display("[TB] FAIL gap_len: got %0d want %0d", acc_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (acc_log[i] !== want[i]) begin
                    miscompares++;
                    $display("[TB] FAIL gap_seq[%0d]: got %h want %h", i, acc_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        fifo_q.push_back(16'hA5C3);
        fifo_q.push_back(16'h4321);
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        acc_log.delete();
        fifo_q.push_back(16'h9876);
        repeat (6) cycle(1'b0, 1'b1);
`ifdef UNPACK_MSB_FIRST_EN
        want = '{4'h9, 4'h8, 4'h7, 4'h6};
`else
        want = '{4'h6, 4'h7, 4'h8, 4'h9};
`endif
        vectors++;
        if (acc_log.size() != want.size()) begin
            miscompares++;
            $display("[TB] FAIL rst_len: got %0d want %0d", acc_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                vectors++;
                if (acc_log[i] !== want[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rst_seq[%0d]: got %h want %h", i, acc_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit rst;
        bit rdy;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) fifo_q.push_back(16'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rst, rdy);
        end
        repeat (40) cycle(1'b0, 1'b1);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        pop_count    = 0;
        reset        = 1'b1;
        out_ready_i  = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty_gap();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
